// File: rtl/pre_norm_mul_pipe_if.sv
// rtl/pre_norm_mul_pipe_if.sv - operand/result handshake bundle for the FP multiplier pre-normaliser
interface pre_norm_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [EXP_W+MAN_W:0]     opa_i;
  logic [EXP_W+MAN_W:0]     opb_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic                     sign_o;
  logic [EXP_W+1:0]         exp_o;
  logic [MAN_W:0]           fracta_o;
  logic [MAN_W:0]           fractb_o;
  logic [1:0]               exp_ovf_o;
  logic                     zero_o;
  logic                     inf_o;
  logic                     nan_o;

  modport slave (
    input  in_valid_i, opa_i, opb_i, out_ready_i,
    output in_ready_o, out_valid_o, sign_o, exp_o, fracta_o, fractb_o,
           exp_ovf_o, zero_o, inf_o, nan_o
  );

  modport master (
    output in_valid_i, opa_i, opb_i, out_ready_i,
    input  in_ready_o, out_valid_o, sign_o, exp_o, fracta_o, fractb_o,
           exp_ovf_o, zero_o, inf_o, nan_o
  );
endinterface

// File: rtl/pre_norm_mul_pipe.sv
// rtl/pre_norm_mul_pipe.sv - two-stage valid/ready pre-normaliser for the FP multiplier
// Define FTZ_INPUT_EN to flush subnormal operands to zero on input.
module pre_norm_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pre_norm_mul_pipe_if.slave    bus
);
  localparam int OP_W = EXP_W + MAN_W + 1;
  localparam logic [EXP_W+1:0] BIAS_V = BIAS[EXP_W+1:0];
  localparam logic [EXP_W+1:0] EMAX_V = {2'b00, {EXP_W{1'b1}}};
  localparam logic [EXP_W-1:0] ONE_E  = {{(EXP_W-1){1'b0}}, 1'b1};

  logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0]   fa_ext, fb_ext;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic             nan_d, inf_d, zero_d;

  assign ea = bus.opa_i[OP_W-2 -: EXP_W];
  assign eb = bus.opb_i[OP_W-2 -: EXP_W];
  assign fa = bus.opa_i[MAN_W-1:0];
  assign fb = bus.opb_i[MAN_W-1:0];

  always_comb begin
    ea_eff = (ea == '0) ? ONE_E : ea;
    eb_eff = (eb == '0) ? ONE_E : eb;
    a_inf  = (&ea) && (fa == '0);
    b_inf  = (&eb) && (fb == '0);
    a_nan  = (&ea) && (fa != '0);
    b_nan  = (&eb) && (fb != '0);
`ifdef FTZ_INPUT_EN
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    fa_ext = a_zero ? '0 : {1'b1, fa};
    fb_ext = b_zero ? '0 : {1'b1, fb};
`else
    a_zero = (ea == '0) && (fa == '0);
    b_zero = (eb == '0) && (fb == '0);
    fa_ext = {(ea != '0), fa};
    fb_ext = {(eb != '0), fb};
`endif
    nan_d  = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
    inf_d  = (a_inf || b_inf) && !nan_d;
    zero_d = (a_zero || b_zero) && !nan_d;
  end

  logic             s1_valid, s2_valid, s1_adv, s2_adv;
  logic             s1_sign, s1_zero, s1_inf, s1_nan;
  logic [EXP_W-1:0] s1_ea, s1_eb;
  logic [MAN_W:0]   s1_fa, s1_fb;

  assign s2_adv = !s2_valid || bus.out_ready_i;
  assign s1_adv = !s1_valid || s2_adv;
  assign bus.in_ready_o = s1_adv;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_ea    <= '0;
      s1_eb    <= '0;
      s1_fa    <= '0;
      s1_fb    <= '0;
      s1_zero  <= 1'b0;
      s1_inf   <= 1'b0;
      s1_nan   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid_i;
      if (bus.in_valid_i) begin
        s1_sign <= bus.opa_i[OP_W-1] ^ bus.opb_i[OP_W-1];
        s1_ea   <= ea_eff;
        s1_eb   <= eb_eff;
        s1_fa   <= fa_ext;
        s1_fb   <= fb_ext;
        s1_zero <= zero_d;
        s1_inf  <= inf_d;
        s1_nan  <= nan_d;
      end
    end
  end

  // Two guard bits keep the sum of two max exponents and the negative bias-adjusted result exact.
  logic [EXP_W+1:0] exp_sum;
  logic [1:0]       ovf_d;

  always_comb begin
    exp_sum  = {2'b00, s1_ea} + {2'b00, s1_eb} - BIAS_V;
    ovf_d[1] = $signed(exp_sum) >= $signed(EMAX_V);
    ovf_d[0] = exp_sum[EXP_W+1] || (exp_sum == '0);
  end

  logic             s2_sign, s2_zero, s2_inf, s2_nan;
  logic [EXP_W+1:0] s2_exp;
  logic [MAN_W:0]   s2_fa, s2_fb;
  logic [1:0]       s2_ovf;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_exp   <= '0;
      s2_fa    <= '0;
      s2_fb    <= '0;
      s2_ovf   <= '0;
      s2_zero  <= 1'b0;
      s2_inf   <= 1'b0;
      s2_nan   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_exp  <= exp_sum;
        s2_fa   <= s1_fa;
        s2_fb   <= s1_fb;
        s2_ovf  <= ovf_d;
        s2_zero <= s1_zero;
        s2_inf  <= s1_inf;
        s2_nan  <= s1_nan;
      end
    end
  end

  assign bus.out_valid_o = s2_valid;
  assign bus.sign_o      = s2_sign;
  assign bus.exp_o       = s2_exp;
  assign bus.fracta_o    = s2_fa;
  assign bus.fractb_o    = s2_fb;
  assign bus.exp_ovf_o   = s2_ovf;
  assign bus.zero_o      = s2_zero;
  assign bus.inf_o       = s2_inf;
  assign bus.nan_o       = s2_nan;
endmodule

// File: tb/tb_pre_norm_mul_pipe.sv
// tb/tb_pre_norm_mul_pipe.sv - directed vector bench for pre_norm_mul_pipe (FP32 and FP16 builds)
module tb_pre_norm_mul_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pre_norm_mul_pipe_if #(.EXP_W(8), .MAN_W(23)) f_if ();
  pre_norm_mul_pipe_if #(.EXP_W(5), .MAN_W(10)) h_if ();

  pre_norm_mul_pipe #(.EXP_W(8), .MAN_W(23), .BIAS(127)) u_f (.clk_i(clk), .rst_i(rst), .bus(f_if));
  pre_norm_mul_pipe #(.EXP_W(5), .MAN_W(10), .BIAS(15))  u_h (.clk_i(clk), .rst_i(rst), .bus(h_if));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] fa;
    logic [23:0] fb;
    logic [1:0]  ovf;
    logic        zero;
    logic        inf;
    logic        nan;
  } vec_t;

  localparam int NV = 9;
  vec_t vt [NV];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic s, logic [9:0] e,
                              logic [23:0] fa, logic [23:0] fb, logic [1:0] ovf,
                              logic z, logic i, logic n);
    vec_t v;
    v.a = a; v.b = b; v.sign = s; v.exp = e; v.fa = fa; v.fb = fb;
    v.ovf = ovf; v.zero = z; v.inf = i; v.nan = n;
    return v;
  endfunction

  function automatic logic [63:0] exp_pack(vec_t v);
    return {v.sign, v.exp, v.fa, v.fb, v.ovf, v.zero, v.inf, v.nan};
  endfunction

  function automatic logic [63:0] pack_f();
    return {f_if.sign_o, f_if.exp_o, f_if.fracta_o, f_if.fractb_o, f_if.exp_ovf_o,
            f_if.zero_o, f_if.inf_o, f_if.nan_o};
  endfunction

  function automatic logic [63:0] pack_h();
    return {29'd0, h_if.sign_o, h_if.exp_o, h_if.fracta_o, h_if.fractb_o, h_if.exp_ovf_o,
            h_if.zero_o, h_if.inf_o, h_if.nan_o};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic run_vec(input int i);
    int lat;
    @(negedge clk);
    f_if.opa_i = vt[i].a;
    f_if.opb_i = vt[i].b;
    f_if.in_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    f_if.in_valid_i = 1'b0;
    lat = 1;
    while (!f_if.out_valid_o && lat < 8) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency_v%0d", i), 64'(lat), 64'd2);
    chk($sformatf("result_v%0d", i), pack_f(), exp_pack(vt[i]));
  endtask

  task automatic run_h(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [63:0] req);
    int lat;
    @(negedge clk);
    h_if.opa_i = a;
    h_if.opb_i = b;
    h_if.in_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    h_if.in_valid_i = 1'b0;
    lat = 1;
    while (!h_if.out_valid_o && lat < 8) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk({name, "_valid"}, 64'(h_if.out_valid_o), 64'd1);
    chk(name, pack_h(), req);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx, got;
    logic held, acc;
    logic [63:0] snap;

    vt[0] = mk(32'h3FC00000, 32'h40000000, 1'b0, 10'h080, 24'hC00000, 24'h800000, 2'b00, 1'b0, 1'b0, 1'b0);
    vt[1] = mk(32'h7F000000, 32'h7F000000, 1'b0, 10'h17D, 24'h800000, 24'h800000, 2'b10, 1'b0, 1'b0, 1'b0);
    vt[2] = mk(32'h00800000, 32'h80800000, 1'b1, 10'h383, 24'h800000, 24'h800000, 2'b01, 1'b0, 1'b0, 1'b0);
`ifdef FTZ_INPUT_EN
    vt[3] = mk(32'h00000001, 32'h3F800000, 1'b0, 10'h001, 24'h000000, 24'h800000, 2'b00, 1'b1, 1'b0, 1'b0);
`else
    vt[3] = mk(32'h00000001, 32'h3F800000, 1'b0, 10'h001, 24'h000001, 24'h800000, 2'b00, 1'b0, 1'b0, 1'b0);
`endif
    vt[4] = mk(32'h7F800000, 32'h00000000, 1'b0, 10'h081, 24'h800000, 24'h000000, 2'b00, 1'b0, 1'b0, 1'b1);
    vt[5] = mk(32'hFF800000, 32'h3F800000, 1'b1, 10'h0FF, 24'h800000, 24'h800000, 2'b10, 1'b0, 1'b1, 1'b0);
    vt[6] = mk(32'h7FC00000, 32'h3F800000, 1'b0, 10'h0FF, 24'hC00000, 24'h800000, 2'b10, 1'b0, 1'b0, 1'b1);
    vt[7] = mk(32'h80000000, 32'h3F800000, 1'b1, 10'h001, 24'h000000, 24'h800000, 2'b00, 1'b1, 1'b0, 1'b0);
    vt[8] = mk(32'h7F800000, 32'h7F800000, 1'b0, 10'h17F, 24'h800000, 24'h800000, 2'b10, 1'b0, 1'b1, 1'b0);

    // reset held with a valid operand pair waiting
    rst = 1'b1;
    f_if.in_valid_i = 1'b1;
    f_if.opa_i = vt[0].a;
    f_if.opb_i = vt[0].b;
    f_if.out_ready_i = 1'b1;
    h_if.in_valid_i = 1'b0;
    h_if.opa_i = '0;
    h_if.opb_i = '0;
    h_if.out_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst_valid_c%0d", c), 64'(f_if.out_valid_o), 64'd0);
      chk($sformatf("rst_data_c%0d", c), pack_f(), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(f_if.in_ready_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    f_if.in_valid_i = 1'b0;
    chk("first_accept_stage1", 64'(f_if.out_valid_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("first_accept_valid", 64'(f_if.out_valid_o), 64'd1);
    chk("first_accept_data", pack_f(), exp_pack(vt[0]));
    @(negedge clk);
    chk("first_accept_single", 64'(f_if.out_valid_o), 64'd0);

    for (int i = 0; i < NV; i++) run_vec(i);

    // reset while a pair is in flight discards it
    @(negedge clk);
    f_if.opa_i = vt[1].a;
    f_if.opb_i = vt[1].b;
    f_if.in_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    f_if.in_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("midflight_rst_valid", 64'(f_if.out_valid_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("midflight_drop_c%0d", c), 64'(f_if.out_valid_o), 64'd0);
    end

    // backpressure: five pairs, output stalled for the first seven cycles
    idx = 0;
    got = 0;
    held = 1'b0;
    snap = '0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      @(negedge clk);
      f_if.out_ready_i = (c >= 7);
      f_if.in_valid_i = (idx < 5);
      if (idx < 5) begin
        f_if.opa_i = vt[idx].a;
        f_if.opb_i = vt[idx].b;
      end
      #1;
      if (c == 6) begin
        chk("bp_accepts_before_stall", 64'(idx), 64'd2);
        chk("bp_in_ready_low", 64'(f_if.in_ready_o), 64'd0);
      end
      if (f_if.out_valid_o && !f_if.out_ready_i) begin
        if (held) chk($sformatf("bp_stable_c%0d", c), pack_f(), snap);
        snap = pack_f();
        held = 1'b1;
      end
      if (f_if.out_valid_o && f_if.out_ready_i) begin
        chk($sformatf("bp_out%0d", got), pack_f(), exp_pack(vt[got]));
        got++;
      end
      acc = f_if.in_valid_i && f_if.in_ready_o;
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    f_if.in_valid_i = 1'b0;
    chk("bp_count", 64'(got), 64'd5);
    chk("bp_sent", 64'(idx), 64'd5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp_no_dup_c%0d", c), 64'(f_if.out_valid_o), 64'd0);
    end

    // FP16 build: {sign, exp[6:0], fa[10:0], fb[10:0], ovf, zero, inf, nan}
    run_h("fp16_one_x_two", 16'h3C00, 16'h4000,
          {29'd0, 1'b0, 7'd16, 11'h400, 11'h400, 2'b00, 3'b000});
    run_h("fp16_ovf", 16'h7800, 16'h7800,
          {29'd0, 1'b0, 7'd45, 11'h400, 11'h400, 2'b10, 3'b000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pre_norm_mul_pipe.md
Name: pre_norm_mul_pipe

Overview:
Parametrised, handshaked pre-normalisation stage for the floating-point multiplier.
- Splits two IEEE-style operands of configurable exponent/mantissa width.
- Recovers hidden bits, forms the biased product exponent as a signed value, and flags overflow/underflow and special operands (zero/inf/NaN).
- Two-stage valid/ready pipeline that feeds the mantissa multiplier and post-normaliser; replaces the fixed FP32 single-register pre-norm stage.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width (hidden bit excluded)
BIAS, 127, exponent bias (normally 2^(EXP_W-1)-1)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous, active-high reset
in_valid_i  in  1  operand pair valid
in_ready_o  out  1  stage can accept operand pair
opa_i  in  EXP_W+MAN_W+1  operand A {sign, exp, frac}
opb_i  in  EXP_W+MAN_W+1  operand B
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts result
sign_o  out  1  product sign
exp_o  out  EXP_W+2  signed two's-complement biased product exponent
fracta_o  out  MAN_W+1  {hidden, frac} of A
fractb_o  out  MAN_W+1  {hidden, frac} of B
exp_ovf_o  out  2  [1]=exponent overflow, [0]=exponent underflow
zero_o  out  1  product is exact zero
inf_o  out  1  product is infinity
nan_o  out  1  product is NaN

Behaviour:
- Reset (async, rst_i=1): both stage valid bits clear; out_valid_o=0; all data/flag outputs 0; in_ready_o=1 after reset deasserts. Reset mid-flight discards all in-flight operands; no output is produced for them.
- Transfer rules: input transfer when in_valid_i & in_ready_o; output transfer when out_valid_o & out_ready_i.
- Stage ready: S2 advances when S2 is empty or out_ready_i=1. S1 advances when S1 is empty or S2 advances. in_ready_o = S1 empty or S1 advancing (combinational, no bubble).
- Latency: exactly 2 cycles from input transfer to out_valid_o when out_ready_i is held at 1. Throughput is one pair per cycle.
- Stall: output registers hold stable while out_valid_o=1 and out_ready_i=0. Up to two pairs are buffered (S1 and S2), then in_ready_o drops. No data is dropped or duplicated.
- S1 (register decode):
  - sign = sa ^ sb.
  - Effective exponent e' = (e==0) ? 1 : e.
  - hidden = (e != 0).
  - Per-operand classes: isZero = (e==0 & f==0); isInf = (e==all1 & f==0); isNaN = (e==all1 & f!=0).
- S2 (register arithmetic):
  - exp = e'a + e'b - BIAS, computed at EXP_W+2 bits signed with no wrap.
  - exp_ovf_o[1] = (exp >= 2^EXP_W - 1).
  - exp_ovf_o[0] = (exp <= 0).
- Special-flag rules:
  - nan_o = NaNa | NaNb | (Infa & Zerob) | (Zeroa & Infb).
  - inf_o = (Infa | Infb) & !nan_o.
  - zero_o = (Zeroa | Zerob) & !nan_o.
  - At most one of nan_o/inf_o/zero_o is set.
  - exp_o/exp_ovf_o are still computed arithmetically when a special flag is set; downstream gives the flags priority.
- sign_o is sa ^ sb in all cases, including NaN, zero and inf.
- fracta_o/fractb_o pass through unmodified except for the hidden-bit insertion.

Optional Feature:
FTZ_INPUT_EN
- Defined: any operand with e==0 (subnormal or zero) is treated as zero: its fraction output is forced to 0, isZero=1, and e'=1 is still used for exp_o.
- Undefined: subnormals pass with hidden=0 and their fraction intact; only a true zero sets isZero.

Test Plan:
- Reset with in_valid_i=1 held -> out_valid_o=0 and all outputs 0 for 3 cycles; first accept happens on the first clock after rst_i falls.
- FP32 defaults, opa=0x3FC00000, opb=0x40000000, out_ready_i=1 -> 2 cycles later sign_o=0, exp_o=0x080, fracta_o=0xC00000, fractb_o=0x800000, exp_ovf_o=00, flags 0.
- Range cases:
  - 0x7F000000 x 0x7F000000 -> exp_o=381, exp_ovf_o=10.
  - 0x00800000 x 0x80800000 -> exp_o=-125 (0x383), exp_ovf_o=01, sign_o=1.
  - 0x00000001 x 0x3F800000 -> exp_o=1, fracta_o=0x000001 (FTZ_INPUT_EN undefined) or zero_o=1, fracta_o=0 (FTZ_INPUT_EN defined).
- Specials:
  - 0x7F800000 x 0x00000000 -> nan_o=1, inf_o=0, zero_o=0.
  - 0xFF800000 x 0x3F800000 -> inf_o=1, sign_o=1.
  - 0x7FC00000 x anything -> nan_o=1.
- Backpressure: stream 5 pairs with out_ready_i=0 for cycles 2-6 -> in_ready_o falls after 2 accepts, outputs stay stable while stalled; after release, all 5 results emerge in order with no loss or duplication.
- Parameter sweep EXP_W=5, MAN_W=10, BIAS=15 (FP16): 0x3C00 x 0x4000 -> exp_o=16, fracta_o=0x400, fractb_o=0x400; 0x7800 x 0x7800 -> exp_o=45, exp_ovf_o=10.
